// File: rtl/branch_predictor.sv
// branch_predictor: table of 2-bit saturating counters that predicts branch
// direction for the fetch stage. The execute stage trains it with each
// resolved outcome, and the block counts branches and mispredicts.
// Defining BP_GSHARE_EN switches the index to gshare, where the PC index bits
// are XORed with a global history register. Without it the index is bimodal.

module branch_predictor #(
   parameter int IDX_BITS = 6,
   parameter int GHR_BITS = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lookup_valid,
   input  logic [31:0]         lookup_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   output logic [IDX_BITS-1:0] pred_idx,
   input  logic                upd_valid,
   input  logic [IDX_BITS-1:0] upd_idx,
   input  logic                upd_taken,
   input  logic                upd_pred,
   output logic [31:0]         br_count,
   output logic [31:0]         mis_count
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [1:0]          cnt_q [ENTRIES];
   logic [1:0]          updCnt_d;
   logic [IDX_BITS-1:0] lookIdx;
   logic [IDX_BITS-1:0] ghrExt;
   logic                predValid_q;
   logic                predTaken_q;
   logic [IDX_BITS-1:0] predIdx_q;
   logic [31:0]         brCount_q;
   logic [31:0]         misCount_q;

   // Only the word-aligned index bits of the PC take part in the lookup.
   logic [31-IDX_BITS:0] unusedPcBits;
   assign unusedPcBits = {lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

`ifdef BP_GSHARE_EN
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;

   // Global history shifts in each resolved outcome, oldest bit falling off.
   always_comb begin
      ghr_d = ghr_q;
      if (upd_valid) begin
         ghr_d = GHR_BITS'({ghr_q, upd_taken});
      end
   end

   // History register; a lookup in the same cycle sees the pre-shift value.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   assign ghrExt = IDX_BITS'(ghr_q);
`else
   // The bimodal build has no history, so the history width goes unused.
   logic [GHR_BITS-1:0] unusedGhrWidth;
   assign unusedGhrWidth = '0;
   assign ghrExt = '0;
`endif

   // Table index for this cycle's lookup.
   always_comb begin
      lookIdx = lookup_pc[IDX_BITS+1:2] ^ ghrExt;
   end

   // Saturating step of the counter being trained.
   always_comb begin
      updCnt_d = cnt_q[upd_idx];
      if (upd_taken) begin
         if (updCnt_d != 2'b11) begin
            updCnt_d = updCnt_d + 2'd1;
         end
      end else begin
         if (updCnt_d != 2'b00) begin
            updCnt_d = updCnt_d - 2'd1;
         end
      end
   end

   // Counter table: reset to weak not-taken, trained one entry per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         cnt_q[upd_idx] <= updCnt_d;
      end
   end

   // Registered prediction; reads the table before this edge's update lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         predValid_q <= 1'b0;
         predTaken_q <= 1'b0;
         predIdx_q   <= '0;
      end else if (lookup_valid) begin
         predValid_q <= 1'b1;
         predTaken_q <= cnt_q[lookIdx][1];
         predIdx_q   <= lookIdx;
      end else begin
         predValid_q <= 1'b0;
      end
   end

   // Branch and mispredict statistics, wrapping naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         brCount_q  <= '0;
         misCount_q <= '0;
      end else if (upd_valid) begin
         brCount_q <= brCount_q + 32'd1;
         if (upd_pred != upd_taken) begin
            misCount_q <= misCount_q + 32'd1;
         end
      end
   end

   assign pred_valid = predValid_q;
   assign pred_taken = predTaken_q;
   assign pred_idx   = predIdx_q;
   assign br_count   = brCount_q;
   assign mis_count  = misCount_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor. A reference counter table and statistics
// model predict each lookup result, which is queued when the lookup is driven
// and compared when the registered prediction appears.

module tb_branch_predictor;

   localparam int IDX_BITS = 6;
   localparam int GHR_BITS = 6;

   typedef struct {
      bit                taken;
      bit [IDX_BITS-1:0] idx;
   } predExp_t;

   logic                clk;
   logic                rst;
   logic                lookupValid;
   logic [31:0]         lookupPc;
   logic                predValid;
   logic                predTaken;
   logic [IDX_BITS-1:0] predIdx;
   logic                updValid;
   logic [IDX_BITS-1:0] updIdx;
   logic                updTaken;
   logic                updPred;
   logic [31:0]         brCount;
   logic [31:0]         misCount;

   int                  checks;
   int                  errors;
   predExp_t            expQ[$];
   predExp_t            expItem;
   bit [1:0]            modelCnt [1 << IDX_BITS];
   bit [GHR_BITS-1:0]   modelGhr;
   bit [31:0]           modelBr;
   bit [31:0]           modelMis;

   branch_predictor #(
      .IDX_BITS(IDX_BITS),
      .GHR_BITS(GHR_BITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lookup_valid(lookupValid),
      .lookup_pc   (lookupPc),
      .pred_valid  (predValid),
      .pred_taken  (predTaken),
      .pred_idx    (predIdx),
      .upd_valid   (updValid),
      .upd_idx     (updIdx),
      .upd_taken   (updTaken),
      .upd_pred    (updPred)
      ,
      .br_count    (brCount),
      .mis_count   (misCount)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one cycle of stimulus, pushes the expected prediction and steps
   // the reference model, then waits until just after the clock edge.
   task automatic applyStimulus(input bit r, input bit lv, input bit [31:0] pc,
                                input bit uv, input bit [IDX_BITS-1:0] ui,
                                input bit ut, input bit up);
      bit [IDX_BITS-1:0] idx;
      predExp_t          e;
      rst         = r;
      lookupValid = lv;
      lookupPc    = pc;
      updValid    = uv;
      updIdx      = ui;
      updTaken    = ut;
      updPred     = up;
      if (r) begin
         for (int i = 0; i < (1 << IDX_BITS); i++) modelCnt[i] = 2'b01;
         modelGhr = '0;
         modelBr  = '0;
         modelMis = '0;
         expQ.delete();
      end else begin
`ifdef BP_GSHARE_EN
         idx = pc[IDX_BITS+1:2] ^ IDX_BITS'(modelGhr);
`else
         idx = pc[IDX_BITS+1:2];
`endif
         if (lv) begin
            e.taken = modelCnt[idx][1];
            e.idx   = idx;
            expQ.push_back(e);
         end
         if (uv) begin
            if (ut && modelCnt[ui] != 2'b11) modelCnt[ui] = modelCnt[ui] + 2'd1;
            if (!ut && modelCnt[ui] != 2'b00) modelCnt[ui] = modelCnt[ui] - 2'd1;
            modelGhr = {modelGhr[GHR_BITS-2:0], ut};
            modelBr  = modelBr + 1;
            if (up != ut) modelMis = modelMis + 1;
         end
      end
      @(posedge clk);
      #1;
      rst         = 1'b0;
      lookupValid = 1'b0;
      updValid    = 1'b0;
   endtask

   // Reset values, then a single lookup of 0x14 and the idle cycle after it.
   task automatic test_reset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (predValid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_pred_valid got %0b want 0", predValid);
      end
      checks++;
      if (predTaken !== 1'b0 || predIdx !== '0) begin
         errors++; $display("[TB] FAIL reset_pred got taken=%0b idx=%0d want 0/0", predTaken, predIdx);
      end
      checks++;
      if (brCount !== 32'd0 || misCount !== 32'd0) begin
         errors++; $display("[TB] FAIL reset_stats got br=%0d mis=%0d want 0/0", brCount, misCount);
      end
      applyStimulus(0, 1, 32'h14, 0, 0, 0, 0);
      checks++;
      if (predValid !== 1'b1 || expQ.size() == 0) begin
         errors++; $display("[TB] FAIL first_lookup_valid got %0b want 1", predValid);
      end else begin
         expItem = expQ.pop_front();
         checks++;
         if (predTaken !== expItem.taken || predIdx !== expItem.idx || predIdx !== 6'd5) begin
            errors++;
            $display("[TB] FAIL first_lookup got taken=%0b idx=%0d want taken=%0b idx=%0d",
                     predTaken, predIdx, expItem.taken, expItem.idx);
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (predValid !== 1'b0) begin
         errors++; $display("[TB] FAIL idle_pred_valid got %0b want 0", predValid);
      end
   endtask

   // Counter walks 01 -> 10 -> 11 -> 10 -> 01 with a lookup after each step.
   task automatic test_saturate();
      bit dirs [5] = '{1, 1, 1, 0, 0};
      bit want [5] = '{1, 1, 1, 1, 0};
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      foreach (dirs[k]) begin
         applyStimulus(0, 0, 0, 1, 6'd5, dirs[k], 0);
         applyStimulus(0, 1, 32'h14, 0, 0, 0, 0);
         checks++;
         if (predValid !== 1'b1 || expQ.size() == 0) begin
            errors++; $display("[TB] FAIL saturate_valid step %0d got %0b want 1", k, predValid);
         end else begin
            expItem = expQ.pop_front();
            checks++;
            if (predTaken !== expItem.taken || predTaken !== want[k]) begin
               errors++;
               $display("[TB] FAIL saturate_taken step %0d got %0b want %0b", k, predTaken, want[k]);
            end
         end
      end
   endtask

   // Lookup and update of the same entry in one cycle read the old counter.
   task automatic test_read_old();
      bit want [2] = '{0, 1};
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 1, 32'h14, (k == 0), 6'd5, 1, 0);
         checks++;
         if (predValid !== 1'b1 || expQ.size() == 0) begin
            errors++; $display("[TB] FAIL read_old_valid step %0d got %0b want 1", k, predValid);
         end else begin
            expItem = expQ.pop_front();
            checks++;
            if (predTaken !== expItem.taken || predTaken !== want[k]) begin
               errors++;
               $display("[TB] FAIL read_old_taken step %0d got %0b want %0b", k, predTaken, want[k]);
            end
         end
      end
   endtask

   // Four resolved branches, exactly one mispredicted.
   task automatic test_stats();
      bit pr [4] = '{0, 1, 0, 1};
      bit tk [4] = '{0, 1, 1, 1};
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, IDX_BITS'(k + 9), tk[k], pr[k]);
      checks++;
      if (brCount !== modelBr || brCount !== 32'd4) begin
         errors++; $display("[TB] FAIL stats_br got %0d want 4", brCount);
      end
      checks++;
      if (misCount !== modelMis || misCount !== 32'd1) begin
         errors++; $display("[TB] FAIL stats_mis got %0d want 1", misCount);
      end
   endtask

   // Reset wins over a lookup and update in the same cycle.
   task automatic test_reset_priority();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 6'd5, 1, 0);
      applyStimulus(0, 1, 32'h14, 1, 6'd5, 1, 0);
      applyStimulus(1, 1, 32'h14, 1, 6'd5, 0, 1);
      checks++;
      if (predValid !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_prio_valid got %0b want 0", predValid);
      end
      checks++;
      if (brCount !== 32'd0 || misCount !== 32'd0) begin
         errors++; $display("[TB] FAIL rst_prio_stats got br=%0d mis=%0d want 0/0", brCount, misCount);
      end
      applyStimulus(0, 1, 32'h14, 0, 0, 0, 0);
      checks++;
      if (predValid !== 1'b1 || expQ.size() == 0) begin
         errors++; $display("[TB] FAIL rst_prio_lookup_valid got %0b want 1", predValid);
      end else begin
         expItem = expQ.pop_front();
         checks++;
         if (predTaken !== expItem.taken || predTaken !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_prio_counter got taken=%0b want 0", predTaken);
         end
      end
   endtask

   // Random lookups and updates every cycle against the reference model.
   task automatic test_back_to_back();
      bit lv;
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 300; c++) begin
         lv = ($urandom_range(0, 3) != 0);
         applyStimulus(0, lv, {$urandom_range(0, 255), 2'b00} | ($urandom & 32'hFFFF_FC00),
                       ($urandom_range(0, 2) != 0), IDX_BITS'($urandom_range(0, 15)),
                       1'($urandom), 1'($urandom));
         checks++;
         if (predValid !== lv) begin
            errors++; $display("[TB] FAIL b2b_valid cycle %0d got %0b want %0b", c, predValid, lv);
         end else if (lv) begin
            expItem = expQ.pop_front();
            checks++;
            if (predTaken !== expItem.taken || predIdx !== expItem.idx) begin
               errors++;
               $display("[TB] FAIL b2b_pred cycle %0d got taken=%0b idx=%0d want taken=%0b idx=%0d",
                        c, predTaken, predIdx, expItem.taken, expItem.idx);
            end
         end
      end
      checks++;
      if (brCount !== modelBr || misCount !== modelMis) begin
         errors++;
         $display("[TB] FAIL b2b_stats got br=%0d mis=%0d want br=%0d mis=%0d",
                  brCount, misCount, modelBr, modelMis);
      end
   endtask

`ifdef BP_GSHARE_EN
   // One taken update sets the history to 1, so PC 0 indexes entry 1.
   task automatic test_gshare();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 6'd3, 1, 1);
      applyStimulus(0, 1, 32'h0, 0, 0, 0, 0);
      checks++;
      if (predValid !== 1'b1 || expQ.size() == 0) begin
         errors++; $display("[TB] FAIL gshare_valid got %0b want 1", predValid);
      end else begin
         expItem = expQ.pop_front();
         checks++;
         if (predIdx !== expItem.idx || predIdx !== 6'd1) begin
            errors++; $display("[TB] FAIL gshare_idx got %0d want 1", predIdx);
         end
      end
   endtask
`endif

   // Runs every scenario in order and prints the summary.
   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      lookupValid = 1'b0;
      lookupPc    = '0;
      updValid    = 1'b0;
      updIdx      = '0;
      updTaken    = 1'b0;
      updPred     = 1'b0;
      modelGhr    = '0;
      modelBr     = '0;
      modelMis    = '0;
      test_reset();
      test_saturate();
      test_read_old();
      test_stats();
      test_reset_priority();
      test_back_to_back();
`ifdef BP_GSHARE_EN
      test_gshare();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch-direction predictor for the fetch stage. It holds a table of 2-bit saturating counters and returns a registered taken/not-taken prediction for a fetch PC. It is trained by the execute-stage branch comparator's resolved outcome for SB-type instructions. It also keeps branch and mispredict statistics.

## Interface

Parameters:
- IDX_BITS, 6, log2 of table entries (64 counters)
- GHR_BITS, 6, global history length; used only under BP_GSHARE_EN; must be ≤ IDX_BITS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- lookup_valid  in  1  fetch requests a prediction this cycle
- lookup_pc  in  32  fetch PC
- pred_valid  out  1  prediction registered from the previous cycle's lookup
- pred_taken  out  1  predicted direction
- pred_idx  out  IDX_BITS  table index used; carried down the pipe and returned on upd_idx
- upd_valid  in  1  resolved SB-type branch this cycle
- upd_idx  in  IDX_BITS  pred_idx captured at lookup
- upd_taken  in  1  resolved outcome (comparator branch output)
- upd_pred  in  1  pred_taken originally issued for this branch
- br_count  out  32  resolved branches since reset
- mis_count  out  32  mispredicts since reset

## Operation

- Table of 2**IDX_BITS 2-bit counters held in flops.
  - Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Prediction is counter[1].
- Lookup index is lookup_pc[IDX_BITS+1:2]. Without BP_GSHARE_EN it is used directly; gshare mode XORs in the history, see Configuration.
- Update on upd_valid, applied to entry upd_idx:
  - upd_taken=1: increment the counter, saturating at 11.
  - upd_taken=0: decrement the counter, saturating at 00.
- Statistics:
  - br_count increments on every upd_valid.
  - mis_count increments when upd_valid && (upd_pred != upd_taken).
  - Both wrap modulo 2**32.
- Reset state:
  - every counter = 01
  - pred_valid=0, pred_taken=0, pred_idx=0
  - br_count=0, mis_count=0
  - GHR=0
- Reset has priority over lookup and update in the same cycle.
- Reset mid-operation discards any in-flight prediction: pred_valid=0 in the cycle after rst.

## Timing

- Lookup latency is 1 cycle. At the edge where lookup_valid=1, the block registers:
  - pred_valid ← 1
  - pred_taken ← table[idx][1]
  - pred_idx ← idx
- At an edge with lookup_valid=0: pred_valid ← 0; pred_taken and pred_idx hold.
- Update takes effect at the edge where upd_valid=1. A lookup of that entry in the following cycle sees the new counter.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update counter (read-old); the update is still applied.
- Lookup and update are independent ports. One of each is accepted every cycle, with no stall or backpressure.
- br_count and mis_count are visible the cycle after the qualifying update.

## Configuration

- BP_GSHARE_EN defined:
  - A GHR_BITS-wide global history register shifts on each upd_valid: GHR ← {GHR[GHR_BITS-2:0], upd_taken}. History is non-speculative.
  - Lookup index = lookup_pc[IDX_BITS+1:2] XOR zero-extended GHR.
  - Same-cycle lookup and update: the lookup uses the pre-shift GHR.
- BP_GSHARE_EN undefined:
  - No GHR flops.
  - Index = lookup_pc[IDX_BITS+1:2] (bimodal).

## Test plan

- Reset, then lookup_pc=0x00000014 → next cycle pred_valid=1, pred_taken=0, pred_idx=5; one cycle later pred_valid=0.
- Two updates to idx 5 with upd_taken=1, then lookup of 0x14 → pred_taken=1 (counter 11). One further not-taken update → still taken (counter 10). A second not-taken update → pred_taken=0.
- Lookup 0x14 and update idx 5 taken in the same cycle, counter at 01 → pred_taken=0; next lookup → pred_taken=1.
- Four updates with (pred, taken) = (0,0), (1,1), (0,1), (1,1) → br_count=4, mis_count=1.
- rst asserted in the same cycle as lookup_valid and upd_valid, counter 5 previously at 11 → pred_valid=0 next cycle; counter 5 reads 01; both statistics counters are 0.
- BP_GSHARE_EN: after reset, one taken update (GHR=1), then lookup_pc=0x00000000 → pred_idx=1.
